// File: rtl/fft_frame_scheduler_pkg.sv
// Shared state encoding and default geometry for the FFT frame scheduler.
package fft_frame_scheduler_pkg;

  localparam int DEF_N_FFT  = 256;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_TO_CYC = 4096;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_UNLOAD = 3'd4,
    S_ERR    = 3'd5
  } sched_state_e;

  // Working memory belongs to the FFT core only while it is being kicked off or running.
  function automatic logic fft_owns_mem(input sched_state_e s);
    return (s == S_START) || (s == S_RUN);
  endfunction

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Host-side streaming and memory-port bundle between host logic and the scheduler.
interface fft_frame_scheduler_if
  import fft_frame_scheduler_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              iLOAD_VALID;
  logic              oLOAD_READY;
  logic              iUNLOAD_READY;
  logic              oUNLOAD_VALID;
  logic [ADDR_W-1:0] oADDR_HOST;
  logic              oWE_HOST;

  modport master (
    output iLOAD_VALID,
    output iUNLOAD_READY,
    input  oLOAD_READY,
    input  oUNLOAD_VALID,
    input  oADDR_HOST,
    input  oWE_HOST
  );

  modport slave (
    input  iLOAD_VALID,
    input  iUNLOAD_READY,
    output oLOAD_READY,
    output oUNLOAD_VALID,
    output oADDR_HOST,
    output oWE_HOST
  );
endinterface

// File: rtl/fft_frame_scheduler_watchdog.sv
// Run-phase watchdog: cleared on FFT start, counts while enabled, saturates at TO_CYC-1.
module fft_frame_scheduler_watchdog
  import fft_frame_scheduler_pkg::*;
#(
  parameter int TO_CYC = DEF_TO_CYC
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic first_o,
  output logic expired_o
);
  localparam int WD_W = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
  localparam logic [WD_W-1:0] LAST_CNT = WD_W'(TO_CYC - 1);

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero count while running marks the first RUN cycle, where FFT-done is not trusted yet.
  assign first_o   = (cnt_q == '0);
  assign expired_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/fft_frame_scheduler.sv
// Frame sequencer: host load -> FFT start -> wait done -> host unload, with watchdog and frame count.
module fft_frame_scheduler
  import fft_frame_scheduler_pkg::*;
#(
  parameter int N_FFT  = DEF_N_FFT,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TO_CYC = DEF_TO_CYC,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  fft_frame_scheduler_if.slave host,
  input  logic                 iABORT,
  input  logic                 iFFT_RDY,
  output logic                 oSEL_FFT,
  output logic                 oFFT_START,
  output logic                 oBUSY,
  output logic                 oERR_TIMEOUT,
  output logic [CNT_W-1:0]     oFRAME_CNT
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_FFT - 1);

  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]  frame_q, frame_d;
  logic              load_ready_q;
  logic              unload_valid_q;
  logic              sel_fft_q;
  logic              start_q;
  logic              busy_q;
  logic              err_q;

  logic              load_hs;
  logic              unload_hs;
  logic              abort_act;
  logic              wd_clr;
  logic              wd_en;
  logic              wd_first;
  logic              wd_expired;

  fft_frame_scheduler_watchdog #(
    .TO_CYC(TO_CYC)
  ) u_watchdog (
    .clk_i    (iCLK),
    .rst_i    (iRESET),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .first_o  (wd_first),
    .expired_o(wd_expired)
  );

  assign abort_act = iABORT && (state_q != S_IDLE);
  assign load_hs   = host.iLOAD_VALID && load_ready_q;
  assign unload_hs = unload_valid_q && host.iUNLOAD_READY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_hs) begin
          cnt_d   = cnt_q + ADDR_W'(1);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_hs) begin
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      S_START: begin
        wd_clr  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        wd_en = 1'b1;
        // Done beats expiry when both land in the same cycle.
        if (iFFT_RDY && !wd_first) begin
          state_d = S_UNLOAD;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_UNLOAD: begin
        if (unload_hs) begin
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            frame_d = frame_q + CNT_W'(1);
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_act) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      frame_d = frame_q;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      frame_q        <= '0;
      load_ready_q   <= 1'b0;
      unload_valid_q <= 1'b0;
      sel_fft_q      <= 1'b0;
      start_q        <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      frame_q        <= frame_d;
      load_ready_q   <= (state_d == S_IDLE) || (state_d == S_LOAD);
      unload_valid_q <= (state_d == S_UNLOAD);
      sel_fft_q      <= fft_owns_mem(state_d);
      start_q        <= (state_d == S_START);
      busy_q         <= (state_d != S_IDLE);
      if (state_d == S_ERR) begin
        err_q <= 1'b1;
      end
    end
  end

  // An abort in LOAD cancels the beat, so the write strobe is withheld as well.
  assign host.oWE_HOST      = load_hs && !(iABORT && (state_q == S_LOAD));
  assign host.oLOAD_READY   = load_ready_q;
  assign host.oUNLOAD_VALID = unload_valid_q;
  assign host.oADDR_HOST    = cnt_q;
  assign oSEL_FFT           = sel_fft_q;
  assign oFFT_START         = start_q;
  assign oBUSY              = busy_q;
  assign oERR_TIMEOUT       = err_q;
  assign oFRAME_CNT         = frame_q;

endmodule
